// File: rtl/mips_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } md_state_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [MD_WIDTH-1:0] cond_neg(input logic [MD_WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the multiply/divide datapath on the 64-bit work register.
// Multiply: work = {acc, multiplier}; add operand when multiplier LSB is set, shift right.
// Divide:   work = {rem, quotient};   restoring trial subtract, shift left a quotient bit in.
module md_iter_step
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] work_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] work_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Single-cycle add/shift or trial-subtract/shift.
  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    work_out = work_in;
    if (is_div) begin
      shifted = work_in[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, operand};
      if (!diff[WIDTH]) begin
        work_out = {diff[WIDTH-1:0], work_in[WIDTH-2:0], 1'b1};
      end else begin
        work_out = {shifted[WIDTH-1:0], work_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, work_in[2*WIDTH-1:WIDTH]} +
                 (work_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      work_out = {sum, work_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO registers.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(MD_ITER);

  md_state_t          state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] work, work_step;
  logic [WIDTH-1:0]   operand;
  logic               op_div, neg_main, neg_rem, div_zero;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  md_op_t             op_in;
  logic               in_signed, in_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in     = md_op_t'(Op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
  assign abs_a     = cond_neg(OpA, in_signed && OpA[WIDTH-1]);
  assign abs_b     = cond_neg(OpB, in_signed && OpB[WIDTH-1]);

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_div),
    .work_in  (work),
    .operand  (operand),
    .work_out (work_step)
  );

  // Sign restoration of the finished magnitude result; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_fix = neg_main ? (~work + 1'b1) : work;
    quo_fix  = div_zero ? '1 : cond_neg(work[WIDTH-1:0], neg_main);
    rem_fix  = cond_neg(work[2*WIDTH-1:WIDTH], neg_rem);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE -> CALC on Start, 32 iterations, one FIX cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (Start) state_next = ST_CALC;
      ST_CALC: if (cnt == CW'(MD_ITER - 1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, iteration, HI/LO writes and the Done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= '0;
      work     <= '0;
      operand  <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (HiWe) hi_q <= WrData;
          if (LoWe) lo_q <= WrData;
          if (Start) begin
            work     <= {{WIDTH{1'b0}}, abs_a};
            operand  <= abs_b;
            op_div   <= in_div;
            neg_main <= in_signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            neg_rem  <= in_signed && OpA[WIDTH-1];
            div_zero <= in_div && (OpB == '0);
            cnt      <= '0;
          end
        end
        ST_CALC: begin
          work <= work_step;
          cnt  <= cnt + 1'b1;
        end
        ST_FIX: begin
          if (op_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != ST_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit owning the HI/LO registers of the MIPS datapath. It sits in the EX stage beside the ALU, and its Hi/Lo outputs feed the writeback-select 2:1 mux (MFHI/MFLO path). Operations are MULT, MULTU, DIV and DIVU, plus direct HI/LO writes for MTHI and MTLO. Each operation takes a fixed 34 cycles, and Busy lets the hazard unit stall dependent MFHI/MFLO instructions.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request an operation; sampled only in IDLE.
- Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- OpA, OpB  input  32  rs and rt operands; captured when Start is accepted.
- HiWe, LoWe  input  1  MTHI/MTLO write enables; honoured only in IDLE.
- WrData  input  32  data for HiWe and LoWe.
- Busy  output  1  high whenever the state is not IDLE.
- Done  output  1  one-cycle pulse in the cycle after Hi/Lo receive a result.
- Hi, Lo  output  32  architectural HI and LO registers.

Clock and reset are fixed: one clock, reset is synchronous and active-high.

## Operation
- **States:** IDLE, CALC and FIX.
- **IDLE:**
  - Start=1 captures |OpA| and |OpB| into internal registers.
  - Absolute values are taken only for signed ops (MULT, DIV); unsigned ops capture the raw values.
  - The op and the result signs are latched: product sign = A31^B31; quotient sign = A31^B31; remainder sign = A31.
  - The 5-bit counter is cleared and the state moves to CALC.
- **CALC:** one iteration per cycle; after 32 iterations (counter = 31) the state moves to FIX.
  - Multiply: shift-add on a 64-bit {acc, multiplier} register.
  - Divide: restoring algorithm; the 33-bit trial subtraction yields one quotient bit per cycle.
- **FIX:**
  - Apply two's-complement negation according to the latched signs.
  - Write Hi/Lo: multiply gives Hi = product[63:32] and Lo = product[31:0]; divide gives Lo = quotient and Hi = remainder.
  - Set Done for the next cycle and return to IDLE.
- **Divide by zero:** no trap. Result is Lo = 32'hFFFFFFFF, Hi = OpA as captured (sign-restored to the original OpA). Latency is the same 34 cycles.
- **DIV 0x80000000 / 0xFFFFFFFF:** Lo = 0x80000000, Hi = 0. This follows naturally from the abs/negate path.
- **Ignored inputs while Busy:**
  - Start is ignored; there is no queueing.
  - HiWe and LoWe are ignored.
- **HiWe/LoWe in IDLE:** writes WrData on the next edge.
- **Start together with HiWe/LoWe in IDLE:** both take effect. The write lands now and the result overwrites Hi/Lo at FIX.
- **Outside FIX:** Hi and Lo hold their values; intermediate values are never visible on Hi/Lo.

## Timing
- **Reset (synchronous):** state = IDLE, Busy = 0, Done = 0, Hi = 0, Lo = 0, counter = 0. Reset asserted mid-operation aborts it with no Hi/Lo update and no Done.
- **Latency:**
  - Start is accepted at edge k.
  - Busy = 1 from after edge k through edge k+33.
  - Hi/Lo are updated at edge k+33.
  - Done = 1 for the single cycle between edges k+33 and k+34.
  - Busy = 0 in that same cycle.
- **Back-to-back:** Start may be asserted in the Done cycle. It is accepted at edge k+34, giving a throughput of one operation per 34 cycles.
- **Outputs:** all are registered; there is no combinational path from inputs to outputs.

## Structure
- **Package `mips_pkg`:**
  - Op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - State encoding: ST_IDLE, ST_CALC, ST_FIX.
  - Constant MD_ITER = 32.
- **Sub-module:** one is natural, `md_iter_step`. It is the combinational single-iteration datapath (add/shift for multiply, trial-subtract/shift for divide).
- **Top level:** holds the FSM, the counter, the sign latches and the HI/LO registers.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> at edge k+33, Hi = 0xFFFFFFFE, Lo = 0x00000001; Done pulses 1 cycle; Busy is high for 33 cycles.
- **MULT:** -3 × 7 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB.
- **DIV:** -7 / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF.
- **DIVU and boundary divides:**
  - DIVU 100 / 7 -> Lo = 14, Hi = 2.
  - DIV 0x80000000 / -1 -> Lo = 0x80000000, Hi = 0.
  - DIVU 5 / 0 -> Lo = 0xFFFFFFFF, Hi = 5.
- **Ignored inputs while Busy:**
  - Second Start mid-CALC -> ignored; the first result is unchanged and only one Done is produced.
  - HiWe with WrData = 0x1234 during Busy -> Hi is unchanged.
- **Reset and back-to-back:**
  - Reset at cycle 10 of a MULT -> Hi = Lo = 0, Busy = 0, no Done.
  - Start in the Done cycle -> accepted; the second Done arrives exactly 34 cycles later.
